// File: rtl/sync_exec.sv
// Timed burst executor: arms on a command, waits for TIME_START, then runs blank/pulse/blank and requests the next command.
// Optional linear-FM stepping of FREQ_OUT is compiled in with SYNC_EXEC_LFM_EN.
module sync_exec #(
    parameter int unsigned REQ_LEN        = 4,
    parameter int unsigned TRACE_EN_DUMMY = 0
) (
    input  logic        CLK,
    input  logic        rst_n,
    input  logic [63:0] TIME,
    input  logic        DATA_WR,
    input  logic [47:0] FREQ,
    input  logic [47:0] FREQ_STEP,
    input  logic [31:0] FREQ_RATE,
    input  logic [63:0] TIME_START,
    input  logic [15:0] N_impulse,
    input  logic [1:0]  TYPE_impulse,
    input  logic [31:0] Interval_Ti,
    input  logic [31:0] Interval_Tp,
    input  logic [31:0] Tblank1,
    input  logic [31:0] Tblank2,
    output logic        REQ_COMM,
    output logic        IMP,
    output logic        BLANK,
    output logic [47:0] FREQ_OUT,
    output logic        FREQ_LD,
    output logic        BUSY,
    output logic        ERR_LATE
);

    // IDLE: no command | ARMED: waiting for start time | BLANK1: pre-blank
    // PULSE: pulse periods | BLANK2: post-blank | DONE: REQ_COMM for REQ_LEN clocks
    typedef enum logic [2:0] {IDLE, ARMED, BLANK1, PULSE, BLANK2, DONE} state_t;

    typedef struct packed {
        logic [47:0] freq;
        logic [47:0] step;
        logic [31:0] rate;
        logic [63:0] tstart;
        logic [15:0] n;
        logic [1:0]  typ;
        logic [31:0] ti;
        logic [31:0] tp;
        logic [31:0] tb1;
        logic [31:0] tb2;
    } cmd_t;

    localparam logic [31:0] REQ_LAST = 32'(REQ_LEN - 1);

    state_t      state_q, state_d;
    cmd_t        cur_q, cur_d, sh_q, sh_d, wr_cmd, acc_cmd;
    logic        sh_vld_q, sh_vld_d;
    logic [31:0] cnt_q, cnt_d;
    logic [15:0] pls_q, pls_d;
    logic        err_q, err_d;
    logic [47:0] freq_q, freq_d;
    logic        ld_q, ld_d;
    logic [31:0] per_w, thr_w;
    logic        accept, start_ev, per_start;
    logic        from_start, from_b1, from_pl, go_done;
`ifdef SYNC_EXEC_LFM_EN
    logic [31:0] rate_q, rate_d;
`endif

    assign wr_cmd = '{freq: FREQ, step: FREQ_STEP, rate: FREQ_RATE, tstart: TIME_START,
                      n: N_impulse, typ: TYPE_impulse, ti: Interval_Ti, tp: Interval_Tp,
                      tb1: Tblank1, tb2: Tblank2};

    // A zero-length period would underflow the down-counter, so it runs as one clock.
    always_comb begin
        per_w = (cur_q.tp > cur_q.ti) ? cur_q.tp : cur_q.ti;
        if (per_w == 32'd0) per_w = 32'd1;
        thr_w = per_w - cur_q.ti;
    end

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        sh_d       = sh_q;
        sh_vld_d   = sh_vld_q;
        cnt_d      = cnt_q;
        pls_d      = pls_q;
        err_d      = err_q;
        acc_cmd    = wr_cmd;
        accept     = 1'b0;
        start_ev   = 1'b0;
        per_start  = 1'b0;
        from_start = 1'b0;
        from_b1    = 1'b0;
        from_pl    = 1'b0;
        go_done    = 1'b0;

        case (state_q)
            IDLE: accept = DATA_WR;
            ARMED: begin
                if (DATA_WR) begin
                    accept = 1'b1;
                end else if (TIME >= cur_q.tstart) begin
                    start_ev   = 1'b1;
                    from_start = 1'b1;
                end
            end
            BLANK1, PULSE, BLANK2: begin
                if (DATA_WR) begin
                    sh_d     = wr_cmd;
                    sh_vld_d = 1'b1;
                end
                if (cnt_q != 32'd0) begin
                    cnt_d = cnt_q - 32'd1;
                end else if (state_q == BLANK1) begin
                    from_b1 = 1'b1;
                end else if (state_q == BLANK2) begin
                    go_done = 1'b1;
                end else if (pls_q != 16'd0) begin
                    pls_d     = pls_q - 16'd1;
                    cnt_d     = per_w - 32'd1;
                    per_start = 1'b1;
                end else begin
                    from_pl = 1'b1;
                end
            end
            DONE: begin
                if (cnt_q != 32'd0) begin
                    cnt_d = cnt_q - 32'd1;
                    if (DATA_WR) begin
                        sh_d     = wr_cmd;
                        sh_vld_d = 1'b1;
                    end
                end else if (DATA_WR) begin
                    accept = 1'b1;
                end else if (sh_vld_q) begin
                    accept   = 1'b1;
                    acc_cmd  = sh_q;
                    sh_vld_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Zero-length phases fall through to the next one in the same clock.
        if (from_start) begin
            if (cur_q.tb1 != 32'd0) begin
                state_d = BLANK1;
                cnt_d   = cur_q.tb1 - 32'd1;
            end else begin
                from_b1 = 1'b1;
            end
        end
        if (from_b1) begin
            if (cur_q.n != 16'd0) begin
                state_d   = PULSE;
                cnt_d     = per_w - 32'd1;
                pls_d     = cur_q.n - 16'd1;
                per_start = 1'b1;
            end else begin
                from_pl = 1'b1;
            end
        end
        if (from_pl) begin
            if (cur_q.tb2 != 32'd0) begin
                state_d = BLANK2;
                cnt_d   = cur_q.tb2 - 32'd1;
            end else begin
                go_done = 1'b1;
            end
        end
        if (go_done) begin
            state_d = DONE;
            cnt_d   = REQ_LAST;
        end
        if (accept) begin
            if (acc_cmd.tstart < TIME) begin
                err_d   = 1'b1;
                state_d = DONE;
                cnt_d   = REQ_LAST;
            end else begin
                err_d   = 1'b0;
                cur_d   = acc_cmd;
                state_d = ARMED;
                cnt_d   = 32'd0;
            end
        end
    end

    always_comb begin
        freq_d = freq_q;
        if (start_ev) freq_d = cur_q.freq;
`ifdef SYNC_EXEC_LFM_EN
        rate_d = rate_q;
        if (per_start) begin
            freq_d = cur_q.freq;
            rate_d = cur_q.rate - 32'd1;
        end else if (state_q == PULSE && cnt_q != 32'd0 && cur_q.typ == 2'd1 &&
                     cur_q.rate != 32'd0) begin
            if (rate_q == 32'd0) begin
                freq_d = freq_q + cur_q.step;
                rate_d = cur_q.rate - 32'd1;
            end else begin
                rate_d = rate_q - 32'd1;
            end
        end
`endif
        ld_d = start_ev || (freq_d != freq_q);
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cur_q    <= '0;
            sh_q     <= '0;
            sh_vld_q <= 1'b0;
            cnt_q    <= '0;
            pls_q    <= '0;
            err_q    <= 1'b0;
            freq_q   <= '0;
            ld_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            sh_q     <= sh_d;
            sh_vld_q <= sh_vld_d;
            cnt_q    <= cnt_d;
            pls_q    <= pls_d;
            err_q    <= err_d;
            freq_q   <= freq_d;
            ld_q     <= ld_d;
        end
    end

`ifdef SYNC_EXEC_LFM_EN
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) rate_q <= '0;
        else        rate_q <= rate_d;
    end

    logic unused_w;
    assign unused_w = (TRACE_EN_DUMMY != 0);
`else
    logic unused_w;
    assign unused_w = ^{cur_q.step, cur_q.rate, cur_q.typ, per_start, (TRACE_EN_DUMMY != 0)};
`endif

    assign REQ_COMM = (state_q == DONE);
    assign BUSY     = (state_q != IDLE);
    assign BLANK    = (state_q == BLANK1) || (state_q == BLANK2);
    assign IMP      = (state_q == PULSE) && (cnt_q >= thr_w);
    assign FREQ_OUT = freq_q;
    assign FREQ_LD  = ld_q;
    assign ERR_LATE = err_q;

endmodule

// File: tb/tb_sync_exec.sv
// Directed bench for sync_exec: per-window activity statistics compared against hand-computed timelines.
module tb_sync_exec;

    logic        CLK;
    logic        rst_n;
    logic [63:0] TIME;
    logic        DATA_WR;
    logic [47:0] FREQ, FREQ_STEP;
    logic [31:0] FREQ_RATE;
    logic [63:0] TIME_START;
    logic [15:0] N_impulse;
    logic [1:0]  TYPE_impulse;
    logic [31:0] Interval_Ti, Interval_Tp, Tblank1, Tblank2;
    logic        REQ_COMM, IMP, BLANK, FREQ_LD, BUSY, ERR_LATE;
    logic [47:0] FREQ_OUT;

    sync_exec #(.REQ_LEN(4)) dut (
        .CLK(CLK), .rst_n(rst_n), .TIME(TIME), .DATA_WR(DATA_WR),
        .FREQ(FREQ), .FREQ_STEP(FREQ_STEP), .FREQ_RATE(FREQ_RATE),
        .TIME_START(TIME_START), .N_impulse(N_impulse), .TYPE_impulse(TYPE_impulse),
        .Interval_Ti(Interval_Ti), .Interval_Tp(Interval_Tp),
        .Tblank1(Tblank1), .Tblank2(Tblank2),
        .REQ_COMM(REQ_COMM), .IMP(IMP), .BLANK(BLANK), .FREQ_OUT(FREQ_OUT),
        .FREQ_LD(FREQ_LD), .BUSY(BUSY), .ERR_LATE(ERR_LATE)
    );

    always #10 CLK = ~CLK;

    int n_chk, n_fail;
    int imp_cnt, imp_rise, blank_cnt, req_cnt, ld_cnt, busy_cnt;
    logic [63:0] imp_first, imp_last, blank_first, blank_last, req_first, req_last, ld_first;
    logic imp_prev;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic clr_stats();
        imp_cnt = 0; imp_rise = 0; blank_cnt = 0; req_cnt = 0; ld_cnt = 0; busy_cnt = 0;
        imp_first = 0; imp_last = 0; blank_first = 0; blank_last = 0;
        req_first = 0; req_last = 0; ld_first = 0; imp_prev = 1'b0;
    endtask

    task automatic observe();
        if (IMP) begin
            imp_cnt++;
            if (!imp_prev) imp_rise++;
            if (imp_first == 0) imp_first = TIME;
            imp_last = TIME;
        end
        imp_prev = IMP;
        if (BLANK) begin
            blank_cnt++;
            if (blank_first == 0) blank_first = TIME;
            blank_last = TIME;
        end
        if (REQ_COMM) begin
            req_cnt++;
            if (req_first == 0) req_first = TIME;
            req_last = TIME;
        end
        if (FREQ_LD) begin
            ld_cnt++;
            if (ld_first == 0) ld_first = TIME;
        end
        if (BUSY) busy_cnt++;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        TIME = TIME + 64'd1;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            observe();
            step();
        end
    endtask

    task automatic cmd(input logic [63:0] ts, input logic [15:0] n,
                       input logic [31:0] ti, input logic [31:0] tp,
                       input logic [31:0] tb1, input logic [31:0] tb2,
                       input logic [1:0] typ, input logic [47:0] f,
                       input logic [47:0] fs, input logic [31:0] fr);
        TIME_START = ts; N_impulse = n; Interval_Ti = ti; Interval_Tp = tp;
        Tblank1 = tb1; Tblank2 = tb2; TYPE_impulse = typ;
        FREQ = f; FREQ_STEP = fs; FREQ_RATE = fr;
        DATA_WR = 1'b1;
        observe();
        step();
        DATA_WR = 1'b0;
    endtask

    initial begin
        CLK = 1'b0; rst_n = 1'b0; TIME = 64'd0; DATA_WR = 1'b0;
        FREQ = '0; FREQ_STEP = '0; FREQ_RATE = '0; TIME_START = '0;
        N_impulse = '0; TYPE_impulse = '0; Interval_Ti = '0; Interval_Tp = '0;
        Tblank1 = '0; Tblank2 = '0;
        n_chk = 0; n_fail = 0;
        clr_stats();

        #5;
        chk("rst_busy", BUSY, 0);
        chk("rst_outs", {REQ_COMM, IMP, BLANK, FREQ_LD, ERR_LATE}, 0);
        chk("rst_freq", FREQ_OUT, 0);
        step(); step(); step();
        rst_n = 1'b1;
        step(); step();

        // Nominal burst
        TIME = 64'd1000; clr_stats();
        cmd(64'd1100, 16'd3, 32'd10, 32'd20, 32'd5, 32'd4, 2'd0, 48'h1234_5678_9ABC, 48'd0, 32'd0);
        run(250);
        chk("b_imp_cnt", imp_cnt, 30);
        chk("b_imp_rise", imp_rise, 3);
        chk("b_imp_first", imp_first, 1106);
        chk("b_imp_last", imp_last, 1155);
        chk("b_blank_cnt", blank_cnt, 9);
        chk("b_blank_first", blank_first, 1101);
        chk("b_blank_last", blank_last, 1169);
        chk("b_req_cnt", req_cnt, 4);
        chk("b_req_first", req_first, 1170);
        chk("b_req_last", req_last, 1173);
        chk("b_ld_cnt", ld_cnt, 1);
        chk("b_ld_first", ld_first, 1101);
        chk("b_freq", FREQ_OUT, 48'h1234_5678_9ABC);
        chk("b_busy_cnt", busy_cnt, 173);
        chk("b_busy_end", BUSY, 0);

        // Late command
        TIME = 64'd500; clr_stats();
        cmd(64'd400, 16'd2, 32'd3, 32'd5, 32'd1, 32'd1, 2'd0, 48'd7, 48'd0, 32'd0);
        run(20);
        chk("late_imp", imp_cnt, 0);
        chk("late_req_cnt", req_cnt, 4);
        chk("late_req_first", req_first, 501);
        chk("late_err", ERR_LATE, 1);
        chk("late_busy_end", BUSY, 0);

        // Start time equal to TIME, Ti = 0: clears the error, no IMP, timing kept
        TIME = 64'd600; clr_stats();
        cmd(64'd600, 16'd1, 32'd0, 32'd3, 32'd0, 32'd0, 2'd0, 48'd9, 48'd0, 32'd0);
        chk("eq_err_clr", ERR_LATE, 0);
        run(20);
        chk("eq_imp", imp_cnt, 0);
        chk("eq_blank", blank_cnt, 0);
        chk("eq_req_first", req_first, 605);
        chk("eq_req_cnt", req_cnt, 4);
        chk("eq_busy_cnt", busy_cnt, 8);

        // Shadow command written during PULSE
        TIME = 64'd2000; clr_stats();
        cmd(64'd2010, 16'd4, 32'd3, 32'd5, 32'd2, 32'd2, 2'd0, 48'd100, 48'd0, 32'd0);
        run(19);
        cmd(64'd2220, 16'd2, 32'd3, 32'd5, 32'd2, 32'd2, 2'd0, 48'd200, 48'd0, 32'd0);
        run(280);
        chk("sh_imp_cnt", imp_cnt, 18);
        chk("sh_imp_rise", imp_rise, 6);
        chk("sh_imp_last", imp_last, 2230);
        chk("sh_blank_cnt", blank_cnt, 8);
        chk("sh_req_cnt", req_cnt, 8);
        chk("sh_req_first", req_first, 2035);
        chk("sh_req_last", req_last, 2238);
        chk("sh_ld_cnt", ld_cnt, 2);
        chk("sh_freq", FREQ_OUT, 48'd200);
        chk("sh_busy_end", BUSY, 0);

`ifdef SYNC_EXEC_LFM_EN
        // LFM stepping with 48-bit wrap
        TIME = 64'd2500; clr_stats();
        cmd(64'd2505, 16'd2, 32'd6, 32'd6, 32'd0, 32'd0, 2'd1, 48'hFFFF_FFFF_FFF0, 48'd16, 32'd2);
        run(5);
        chk("lfm_f0", FREQ_OUT, 48'hFFFF_FFFF_FFF0);
        chk("lfm_ld0", FREQ_LD, 1);
        run(2);
        chk("lfm_wrap", FREQ_OUT, 48'd0);
        chk("lfm_ld1", FREQ_LD, 1);
        run(2);
        chk("lfm_f16", FREQ_OUT, 48'd16);
        run(2);
        chk("lfm_restart", FREQ_OUT, 48'hFFFF_FFFF_FFF0);
        run(40);
`endif

        // Reset during the second pulse
        TIME = 64'd3000; clr_stats();
        cmd(64'd3002, 16'd3, 32'd4, 32'd8, 32'd0, 32'd2, 2'd0, 48'd55, 48'd0, 32'd0);
        run(11);
        chk("rst_imp_before", IMP, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_imp_drop", IMP, 0);
        chk("rst_busy_drop", BUSY, 0);
        chk("rst_freq_drop", FREQ_OUT, 0);
        step(); step();
        rst_n = 1'b1;
        clr_stats();
        run(100);
        chk("rst_no_req", req_cnt, 0);
        chk("rst_no_imp", imp_cnt, 0);
        chk("rst_no_busy", busy_cnt, 0);

        // N = 0 with no blanking
        TIME = 64'd3200; clr_stats();
        cmd(64'd3205, 16'd0, 32'd5, 32'd10, 32'd0, 32'd0, 2'd0, 48'd77, 48'd0, 32'd0);
        run(30);
        chk("n0_imp", imp_cnt, 0);
        chk("n0_blank", blank_cnt, 0);
        chk("n0_req_first", req_first, 3206);
        chk("n0_req_cnt", req_cnt, 4);
        chk("n0_ld_first", ld_first, 3206);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
